// File: rtl/key_event_reader_pkg.sv
// Shared definitions for the key event reader: event word layout and packing helper.
package key_event_pkg;

  localparam int NKEYS_DEF   = 8;
  localparam int EVT_IDX_W   = $clog2(NKEYS_DEF);
  localparam int EVT_W       = EVT_IDX_W + 1;

  localparam logic EVT_PRESS   = 1'b1;
  localparam logic EVT_RELEASE = 1'b0;

  // Builds {press, idx} for any index width up to 16; the caller keeps the low idx_w+1 bits.
  function automatic logic [16:0] evt_pack(input logic press, input logic [15:0] idx,
                                           input int idx_w);
    logic [16:0] r;
    r = {1'b0, idx};
    r[idx_w[4:0]] = press;
    return r;
  endfunction

endpackage

// File: rtl/key_event_reader_if.sv
// Button inputs, debounced levels and event FIFO handshake of the key event reader.
interface key_event_reader_if #(
  parameter int NKEYS = 8
);
  import key_event_pkg::*;

  localparam int EW = $clog2(NKEYS) + 1;

  logic [NKEYS-1:0] key_n;
  logic [31:0]      debounce_period;
  logic [NKEYS-1:0] key_state;
  logic             evt_valid;
  logic [EW-1:0]    evt_data;
  logic             evt_pop;
  logic             evt_overflow;
  logic             ovf_clr;
  logic             irq;

  modport master (
    output key_n, debounce_period, evt_pop, ovf_clr,
    input  key_state, evt_valid, evt_data, evt_overflow, irq
  );

  modport slave (
    input  key_n, debounce_period, evt_pop, ovf_clr,
    output key_state, evt_valid, evt_data, evt_overflow, irq
  );

endinterface

// File: rtl/key_event_reader_debounce.sv
// One button: 2-flop synchroniser, tick-driven agreement counter and debounced level.
module key_debounce
  import key_event_pkg::*;
#(
  parameter int SAMPLE_CNT = 3
) (
  input  logic clk,
  input  logic RST,
  input  logic key_n,
  input  logic tick,
  output logic key_state,
  output logic flip
);

  localparam int DW = (SAMPLE_CNT > 1) ? $clog2(SAMPLE_CNT) : 1;
  localparam logic [DW-1:0] DCNT_LAST = DW'(SAMPLE_CNT - 1);

  logic          sync1_reg;
  logic          sync2_reg;
  logic          state_reg;
  logic [DW-1:0] dcnt_reg;
  logic          key_s;

  assign key_s = ~sync2_reg;
  // Flip fires on the tick that completes SAMPLE_CNT consecutive disagreeing samples.
  assign flip  = tick && (key_s != state_reg) && (dcnt_reg == DCNT_LAST);

  always_ff @(posedge clk) begin
    if (RST) begin
      sync1_reg <= 1'b1;
      sync2_reg <= 1'b1;
      state_reg <= 1'b0;
      dcnt_reg  <= '0;
    end else begin
      sync1_reg <= key_n;
      sync2_reg <= sync1_reg;
      if (tick) begin
        if (key_s == state_reg) begin
          dcnt_reg <= '0;
        end else if (dcnt_reg == DCNT_LAST) begin
          state_reg <= ~state_reg;
          dcnt_reg  <= '0;
        end else begin
          dcnt_reg <= dcnt_reg + DW'(1);
        end
      end
    end
  end

  assign key_state = state_reg;

endmodule

// File: rtl/key_event_reader.sv
// Debounced push-button reader: tick divider, per-key debouncers, pending-event
// arbiter (lowest index first) and a small event FIFO with sticky overflow.
module key_event_reader
  import key_event_pkg::*;
#(
  parameter int NKEYS      = 8,
  parameter int FIFO_DEPTH = 4,
  parameter int SAMPLE_CNT = 3
) (
  input logic               clk,
  input logic               RST,
  key_event_reader_if.slave bus
);

  localparam int IDX_W = (NKEYS > 1) ? $clog2(NKEYS) : 1;
  localparam int EW    = IDX_W + 1;
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(FIFO_DEPTH);

  logic [31:0]      tcnt_reg;
  logic             tick;
  logic [NKEYS-1:0] state_vec;
  logic [NKEYS-1:0] flip_vec;

  assign tick = (tcnt_reg == bus.debounce_period);

  // A period lowered below the running count simply wraps through 2^32.
  always_ff @(posedge clk) begin
    if (RST)       tcnt_reg <= '0;
    else if (tick) tcnt_reg <= '0;
    else           tcnt_reg <= tcnt_reg + 32'd1;
  end

  genvar gi;
  generate
    for (gi = 0; gi < NKEYS; gi++) begin : g_key
      key_debounce #(.SAMPLE_CNT(SAMPLE_CNT)) u_deb (
        .clk       (clk),
        .RST       (RST),
        .key_n     (bus.key_n[gi]),
        .tick      (tick),
        .key_state (state_vec[gi]),
        .flip      (flip_vec[gi])
      );
    end
  endgenerate

  logic [NKEYS-1:0] pend_reg, pend_next;
  logic [NKEYS-1:0] grant_vec, drain_vec, collide_vec;
  logic [IDX_W-1:0] grant_idx;
  logic [CNT_W-1:0] count_reg, count_next;
  logic [PTR_W-1:0] wr_ptr_reg, rd_ptr_reg;
  logic [EW-1:0]    mem_reg [FIFO_DEPTH];
  logic             pop_eff, push;
  logic [16:0]      packed_evt;
  logic [EW-1:0]    push_data;
  logic             evt_valid_reg;
  logic             ovf_reg, ovf_next;

  always_comb begin
    grant_idx = '0;
    for (int i = NKEYS - 1; i >= 0; i--) begin
      if (pend_reg[i]) grant_idx = IDX_W'(i);
    end
  end

  assign grant_vec  = pend_reg & (~pend_reg + NKEYS'(1));
  assign pop_eff    = bus.evt_pop && (count_reg != '0);
  assign push       = (pend_reg != '0) && ((count_reg != FULL_CNT) || pop_eff);
  assign packed_evt = evt_pack(state_vec[grant_idx], 16'(grant_idx), IDX_W);
  assign push_data  = packed_evt[EW-1:0];

  // A flip landing on a key whose pending bit is not being drained this cycle loses an event.
  always_comb begin
    drain_vec   = push ? grant_vec : '0;
    collide_vec = flip_vec & pend_reg & ~drain_vec;
    pend_next   = (pend_reg & ~drain_vec) | flip_vec;
    ovf_next    = ovf_reg;
    if (collide_vec != '0) ovf_next = 1'b1;
    else if (bus.ovf_clr)  ovf_next = 1'b0;
    count_next  = count_reg;
    if (push && !pop_eff)      count_next = count_reg + CNT_W'(1);
    else if (!push && pop_eff) count_next = count_reg - CNT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (RST) begin
      pend_reg      <= '0;
      count_reg     <= '0;
      wr_ptr_reg    <= '0;
      rd_ptr_reg    <= '0;
      evt_valid_reg <= 1'b0;
      ovf_reg       <= 1'b0;
      for (int i = 0; i < FIFO_DEPTH; i++) mem_reg[i] <= '0;
    end else begin
      pend_reg      <= pend_next;
      count_reg     <= count_next;
      evt_valid_reg <= (count_reg != '0);
      ovf_reg       <= ovf_next;
      if (push) begin
        mem_reg[wr_ptr_reg] <= push_data;
        wr_ptr_reg          <= wr_ptr_reg + PTR_W'(1);
      end
      if (pop_eff) rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
    end
  end

  assign bus.key_state    = state_vec;
  assign bus.evt_valid    = evt_valid_reg;
  assign bus.evt_data     = mem_reg[rd_ptr_reg];
  assign bus.evt_overflow = ovf_reg;
  assign bus.irq          = evt_valid_reg;

endmodule

// File: tb/tb_key_event_reader.sv
// Directed scenarios plus a randomized run scored against a tick-level behavioural model.
module tb_key_event_reader;
  import key_event_pkg::*;

  localparam int NK = 8;
  localparam int FD = 4;
  localparam int SC = 3;

  logic clk = 1'b0;
  logic RST;
  always #5 clk = ~clk;

  key_event_reader_if #(.NKEYS(NK)) bus ();

  key_event_reader #(.NKEYS(NK), .FIFO_DEPTH(FD), .SAMPLE_CNT(SC)) dut (
    .clk (clk),
    .RST (RST),
    .bus (bus)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Behavioural model: raw samples delayed two clocks, a tick every P+1 clocks,
  // and a level accepted after SC consecutive disagreeing ticks.
  bit               model_on = 1'b0;
  logic [NK-1:0]    raw_hist[$];
  logic [NK-1:0]    m_state;
  logic [NK-1:0]    m_seen;
  int               m_streak[NK];
  int               m_cyc;
  logic [3:0]       m_q[$];

  always @(posedge clk) begin
    if (model_on) begin
      if (RST) begin
        raw_hist = {};
        raw_hist.push_back('1);
        raw_hist.push_back('1);
        m_state = '0;
        m_cyc   = 0;
        foreach (m_streak[i]) m_streak[i] = 0;
        m_q.delete();
      end else begin
        m_seen = ~raw_hist[0];
        if (m_cyc % (int'(bus.debounce_period) + 1) == int'(bus.debounce_period)) begin
          for (int i = 0; i < NK; i++) begin
            if (m_seen[i] == m_state[i]) begin
              m_streak[i] = 0;
            end else begin
              m_streak[i]++;
              if (m_streak[i] == SC) begin
                m_state[i]  = ~m_state[i];
                m_streak[i] = 0;
                m_q.push_back({m_state[i], 3'(i)});
              end
            end
          end
        end
        m_cyc++;
        void'(raw_hist.pop_front());
        raw_hist.push_back(bus.key_n);
      end
    end
  end

  task automatic do_reset();
    RST = 1'b1;
    repeat (3) @(negedge clk);
    RST = 1'b0;
  endtask

  task automatic wait_valid(input string tag, input int bound);
    int n = 0;
    while (!bus.evt_valid && n < bound) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_valid"}, bus.evt_valid, 1);
  endtask

  task automatic pop_expect(input string tag, input logic [3:0] exp);
    wait_valid(tag, 200);
    check({tag, "_data"}, bus.evt_data, exp);
    $display("pop %s: key=%0d press=%0b", tag, bus.evt_data[2:0], bus.evt_data[3]);
    bus.evt_pop = 1'b1;
    @(negedge clk);
    bus.evt_pop = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  int   lat;
  bit   popped;
  logic [31:0] exp_evt;

  initial begin
    RST = 1'b1;
    bus.key_n = '0;
    bus.debounce_period = 32'd9;
    bus.evt_pop = 1'b0;
    bus.ovf_clr = 1'b0;
    repeat (3) @(negedge clk);
    RST = 1'b0;
    check("reset_key_state", bus.key_state, 0);
    check("reset_evt_valid", bus.evt_valid, 0);
    check("reset_overflow", bus.evt_overflow, 0);
    check("reset_irq", bus.irq, 0);
    check("reset_evt_data", bus.evt_data, 0);

    // Clean press and release with a 10-clock tick.
    bus.key_n = '1;
    do_reset();
    @(negedge clk);
    bus.key_n[2] = 1'b0;
    lat = 0;
    while (!bus.key_state[2] && lat < 200) begin
      @(negedge clk);
      lat++;
    end
    check("press_latency_in_window", (lat >= 22 && lat <= 42), 1);
    pop_expect("press_k2", 4'b1010);
    check("press_k2_drained", bus.evt_valid, 0);
    bus.key_n[2] = 1'b1;
    pop_expect("release_k2", 4'b0010);
    check("release_k2_state", bus.key_state, 0);

    // Bounce rejection with a tick every clock.
    bus.debounce_period = 32'd0;
    do_reset();
    bus.key_n[5] = 1'b0;
    repeat (2) @(negedge clk);
    bus.key_n[5] = 1'b1;
    repeat (20) @(negedge clk);
    check("bounce_state", bus.key_state, 0);
    check("bounce_no_evt", bus.evt_valid, 0);
    bus.key_n[5] = 1'b0;
    repeat (2) @(negedge clk);
    bus.key_n[5] = 1'b1;
    @(negedge clk);
    bus.key_n[5] = 1'b0;
    repeat (20) @(negedge clk);
    check("bounce_restart_state", bus.key_state, 8'h20);
    pop_expect("bounce_press_k5", 4'b1101);
    check("bounce_single_evt", bus.evt_valid, 0);

    // Simultaneous presses drain lowest index first.
    bus.key_n = '1;
    do_reset();
    bus.key_n = 8'hB5;
    pop_expect("order_k1", 4'b1001);
    pop_expect("order_k3", 4'b1011);
    pop_expect("order_k6", 4'b1110);
    check("order_empty", bus.evt_valid, 0);

    // Full FIFO, pending backlog, collisions and clear priority.
    bus.key_n = '1;
    do_reset();
    bus.key_n = 8'hC0;
    repeat (20) @(negedge clk);
    check("full_valid", bus.evt_valid, 1);
    check("full_head", bus.evt_data, 4'b1000);
    check("full_no_ovf", bus.evt_overflow, 0);
    bus.key_n[5] = 1'b1;
    repeat (10) @(negedge clk);
    check("collision_ovf", bus.evt_overflow, 1);
    bus.ovf_clr = 1'b1;
    @(negedge clk);
    bus.ovf_clr = 1'b0;
    check("ovf_cleared", bus.evt_overflow, 0);
    bus.key_n[5] = 1'b0;
    repeat (4) @(posedge clk);
    @(negedge clk);
    bus.ovf_clr = 1'b1;
    @(negedge clk);
    bus.ovf_clr = 1'b0;
    check("ovf_set_beats_clr", bus.evt_overflow, 1);
    pop_expect("drain_k0", 4'b1000);
    pop_expect("drain_k1", 4'b1001);
    pop_expect("drain_k2", 4'b1010);
    pop_expect("drain_k3", 4'b1011);
    pop_expect("drain_k4", 4'b1100);
    pop_expect("drain_k5", 4'b1101);
    check("drain_empty", bus.evt_valid, 0);

    // Reset in the middle of a debounce with two queued events.
    bus.key_n = '1;
    do_reset();
    bus.key_n = 8'hFC;
    repeat (10) @(negedge clk);
    check("mid_two_queued", bus.evt_valid, 1);
    bus.key_n[7] = 1'b0;
    repeat (4) @(posedge clk);
    @(negedge clk);
    RST = 1'b1;
    @(negedge clk);
    RST = 1'b0;
    check("mid_rst_key_state", bus.key_state, 0);
    check("mid_rst_valid", bus.evt_valid, 0);
    check("mid_rst_ovf", bus.evt_overflow, 0);
    check("mid_rst_data", bus.evt_data, 0);
    pop_expect("redetect_k0", 4'b1000);
    pop_expect("redetect_k1", 4'b1001);
    pop_expect("redetect_k7", 4'b1111);
    check("redetect_state", bus.key_state, 8'h83);

    // Randomized key activity against the model.
    bus.key_n = '1;
    bus.debounce_period = 32'd7;
    model_on = 1'b1;
    do_reset();
    popped = 1'b0;
    for (int cyc = 0; cyc < 3300; cyc++) begin
      @(negedge clk);
      check("rand_key_state", bus.key_state, m_state);
      check("rand_no_ovf", bus.evt_overflow, 0);
      if (popped) begin
        bus.evt_pop = 1'b0;
        popped = 1'b0;
      end else if (bus.evt_valid) begin
        exp_evt = (m_q.size() > 0) ? 32'(m_q.pop_front()) : 32'h1F;
        check("rand_evt", bus.evt_data, exp_evt);
        $display("pop rand: key=%0d press=%0b", bus.evt_data[2:0], bus.evt_data[3]);
        bus.evt_pop = 1'b1;
        popped = 1'b1;
      end
      if (cyc < 3000) begin
        for (int k = 0; k < NK; k++) begin
          if ($urandom_range(0, 99) == 0) bus.key_n[k] = ~bus.key_n[k];
        end
      end
    end
    bus.evt_pop = 1'b0;
    repeat (2) @(negedge clk);
    check("rand_model_drained", m_q.size(), 0);
    check("rand_fifo_drained", bus.evt_valid, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
